sram_access_ctrl: RTL and testbench

- Synchronous request/response front-end that sequences one load or store at a time from the datapath into the asynchronous, unclocked word SRAM model (cs/oe/we/addr/din/dout).
- Sits directly upstream of the SRAM.
- Guarantees address and data are stable before any strobe, and holds the strobe for a fixed number of cycles.
- Drops strobes before address changes, and returns read data or a write acknowledge through a valid/ready response channel.

---
 rtl/sram_access_ctrl.sv | 132 +++++++++++++
 tb/tb_sram_access_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequences one load/store at a time into an asynchronous word SRAM with registered strobes
module sram_access_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        sram_cs,
  output logic        sram_oe,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);
  localparam int WC = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = $clog2(WC + 1);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] STROBE  = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          cs_q, cs_d, oe_q, oe_d, swe_q, swe_d;
  logic [31:0]   addr_q, addr_d, din_q, din_d;
  logic          rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          accept, misal;
  assign req_ready = (state_q == IDLE) && !arst;
  assign busy      = state_q != IDLE;
  assign accept    = req_valid && (state_q == IDLE);
  assign misal     = ALIGN_CHECK && (req_addr[1:0] != 2'b00);
  assign rsp_valid = rvalid_q;
  assign rsp_err   = rerr_q;
  assign rsp_rdata = rdata_q;
  assign sram_cs   = cs_q;
  assign sram_oe   = oe_q;
  assign sram_we   = swe_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  // Strobe registers hold the value for the state being entered, so they fall on the same edge the FSM leaves STROBE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    cs_d     = 1'b0;
    oe_d     = 1'b0;
    swe_d    = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    rvalid_d = rvalid_q;
    rerr_d   = rerr_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        if (misal) begin
          state_d = RELEASE;
          rerr_d  = 1'b1;
        end else begin
          state_d = SETUP;
          addr_d  = req_addr;
          din_d   = req_wdata;
          we_d    = req_we;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cs_d    = 1'b1;
        swe_d   = we_q;
        oe_d    = !we_q;
        cnt_d   = CW'(WC - 1);
      end
      STROBE: begin
        state_d = (cnt_q == '0) ? RELEASE : STROBE;
        cs_d    = cnt_q != '0;
        swe_d   = (cnt_q != '0) && we_q;
        oe_d    = (cnt_q != '0) && !we_q;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        rdata_d = (cnt_q == '0 && !we_q) ? sram_dout : rdata_q;
      end
      RELEASE: begin
        state_d  = RESP;
        rvalid_d = 1'b1;
      end
      RESP: if (rsp_ready) begin
        state_d  = IDLE;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rdata_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      cs_q     <= 1'b0;
      oe_q     <= 1'b0;
      swe_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      cs_q     <= cs_d;
      oe_q     <= oe_d;
      swe_q    <= swe_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: scoreboard bench for sram_access_ctrl with WAIT_CYCLES=1 and WAIT_CYCLES=3 instances
module tb_sram_access_ctrl;
  logic clk = 1'b0, arst = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0, rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
  logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata, sram_addr, sram_din, sram_dout;
  logic sram_cs, sram_oe, sram_we;
  logic v3 = 1'b0, rdy3, we3 = 1'b0, rv3, rr3 = 1'b1, re3, busy3;
  logic [31:0] a3 = '0, wd3 = '0, rd3, sa3, sd3, so3;
  logic cs3, oe3, swe3;
  logic [31:0] mem [0:255];
  logic [31:0] mem3 [0:255];
  logic [32:0] exp_q [$];
  int checks = 0, errors = 0;
  int cs_total = 0, cs3_total = 0, excl_bad = 0;
  logic [31:0] wr_addr = '0, wr_din = '0;
  sram_access_ctrl #(.WAIT_CYCLES(1), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .sram_cs(sram_cs), .sram_oe(sram_oe),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout));
  sram_access_ctrl #(.WAIT_CYCLES(3), .ALIGN_CHECK(1'b1)) dut3 (
    .clk(clk), .arst(arst), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
    .req_addr(a3), .req_wdata(wd3), .rsp_valid(rv3), .rsp_ready(rr3),
    .rsp_rdata(rd3), .rsp_err(re3), .busy(busy3), .sram_cs(cs3), .sram_oe(oe3),
    .sram_we(swe3), .sram_addr(sa3), .sram_din(sd3), .sram_dout(so3));
  assign sram_dout = (sram_cs && sram_oe) ? mem[sram_addr[9:2]] : 32'h0;
  assign so3 = (cs3 && oe3) ? mem3[sa3[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (sram_cs && sram_we) mem[sram_addr[9:2]] <= sram_din;
    if (cs3 && swe3) mem3[sa3[9:2]] <= sd3;
  end
  always @(negedge clk) begin
    if (sram_cs) cs_total++;
    if (cs3) cs3_total++;
    if (sram_cs && sram_we) begin
      wr_addr = sram_addr;
      wr_din = sram_din;
    end
    if ((sram_oe && sram_we) || ((sram_oe || sram_we) && !sram_cs)) excl_bad++;
    if ((oe3 && swe3) || ((oe3 || swe3) && !cs3)) excl_bad++;
  end
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                       input int exp_cs, input string name);
    int n, c0;
    logic [32:0] e;
    c0 = cs_total;
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready got %b want 1", name, req_ready); end
    @(posedge clk);
    exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n != lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, n, lat); end
    e = exp_q.pop_front();
    checks++;
    if ({rsp_err, rsp_rdata} !== e) begin
      errors++; $display("FAIL %s rsp err/rdata got %b/%h want %b/%h", name, rsp_err, rsp_rdata, e[32], e[31:0]);
    end
    if (rsp_ready) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL %s after handshake valid/busy got %b/%b want 0/0", name, rsp_valid, busy);
      end
    end
    checks++;
    if (cs_total - c0 != exp_cs) begin errors++; $display("FAIL %s cs cycles got %0d want %0d", name, cs_total - c0, exp_cs); end
  endtask
  task automatic test_reset();
    checks++;
    if ({sram_cs, sram_oe, sram_we, rsp_valid, rsp_err, busy, req_ready} !== 7'b0 || sram_addr !== 32'h0 || sram_din !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_values got cs%b oe%b we%b v%b e%b busy%b rdy%b addr%h din%h rdata%h want all 0",
        sram_cs, sram_oe, sram_we, rsp_valid, rsp_err, busy, req_ready, sram_addr, sram_din, rsp_rdata);
    end
    @(negedge clk);
    arst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rdy3 !== 1'b1) begin errors++; $display("FAIL reset_release req_ready got %b/%b want 1/1", req_ready, rdy3); end
    @(negedge clk);
  endtask
  task automatic test_store_load();
    issue(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1, "store_0x10");
    checks++;
    if (wr_addr !== 32'h10 || wr_din !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_bus addr/din got %h/%h want 00000010/deadbeef", wr_addr, wr_din);
    end
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, "load_0x10");
  endtask
  task automatic test_misaligned();
    issue(1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, "misaligned_0x12");
  endtask
  task automatic test_backpressure();
    logic [32:0] e;
    int n;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, "bp_load");
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 || sram_cs !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold cycle %0d v%b rdata%h rdy%b cs%b busy%b want 1 deadbeef 0 0 1", i, rsp_valid, rsp_rdata, req_ready, sram_cs, busy);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_handshake v%b rdy%b busy%b want 0 1 0", rsp_valid, req_ready, busy);
    end
    @(posedge clk);
    exp_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept busy got %b want 1", busy); end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL bp_second latency got %0d want 3", n); end
    e = exp_q.pop_front();
    checks++;
    if ({rsp_err, rsp_rdata} !== e) begin errors++; $display("FAIL bp_second rsp got %b/%h want %b/%h", rsp_err, rsp_rdata, e[32], e[31:0]); end
    @(negedge clk);
    issue(1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1, "load_0x40");
  endtask
  task automatic test_wait3();
    int n, c0;
    logic [32:0] e;
    for (int k = 0; k < 2; k++) begin
      c0 = cs3_total;
      we3 = (k == 0); a3 = 32'h20; wd3 = 32'h12345678; v3 = 1'b1;
      @(posedge clk);
      exp_q.push_back({1'b0, (k == 0) ? 32'h0 : 32'h12345678});
      @(negedge clk);
      v3 = 1'b0;
      n = 0;
      while (rv3 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (n != 5) begin errors++; $display("FAIL wait3_%0d latency got %0d want 5", k, n); end
      e = exp_q.pop_front();
      checks++;
      if ({re3, rd3} !== e) begin errors++; $display("FAIL wait3_%0d rsp got %b/%h want %b/%h", k, re3, rd3, e[32], e[31:0]); end
      @(negedge clk);
      checks++;
      if (cs3_total - c0 != 3 || rv3 !== 1'b0) begin
        errors++; $display("FAIL wait3_%0d cs cycles got %0d want 3, valid got %b want 0", k, cs3_total - c0, rv3);
      end
    end
  endtask
  task automatic test_mid_strobe_reset();
    bit seen;
    req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'h11111111; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sram_cs !== 1'b1 || sram_we !== 1'b1) begin errors++; $display("FAIL mrst_strobe cs/we got %b/%b want 1/1", sram_cs, sram_we); end
    #2 arst = 1'b1;
    #1;
    checks++;
    if ({sram_cs, sram_oe, sram_we, rsp_valid, busy, req_ready} !== 6'b0) begin
      errors++; $display("FAIL mrst_async cs%b oe%b we%b v%b busy%b rdy%b want all 0", sram_cs, sram_oe, sram_we, rsp_valid, busy, req_ready);
    end
    @(negedge clk);
    arst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mrst_release req_ready got %b want 1", req_ready); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mrst_no_response got response/busy want none"); end
  endtask
  initial begin
    #3;
    test_reset();
    test_store_load();
    test_misaligned();
    test_backpressure();
    test_wait3();
    test_mid_strobe_reset();
    checks++;
    if (excl_bad != 0) begin errors++; $display("FAIL strobe_exclusive got %0d violations want 0", excl_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
